// File: rtl/sram_arb_if.sv
// AHB-lite link between sram_arb and the SRAM wrapper slave.
// master = arbiter side, slave = SRAM wrapper side.
interface sram_arb_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    modport master (
        output hsel,
        output haddr,
        output hsize,
        output hwrite,
        output hwdata,
        input  hrdata,
        input  hready,
        input  hresp
    );

    modport slave (
        input  hsel,
        input  haddr,
        input  hsize,
        input  hwrite,
        input  hwdata,
        output hrdata,
        output hready,
        output hresp
    );
endinterface

// File: rtl/sram_arb.sv
// Round-robin arbiter sharing one AHB-lite SRAM port among NUM_REQ clients.
// Optional data-phase watchdog: define SRAM_ARB_TIMEOUT_EN.
module sram_arb #(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*32-1:0] req_addr,
    input  logic [NUM_REQ-1:0]    req_wr,
    input  logic [NUM_REQ*3-1:0]  req_size,
    input  logic [NUM_REQ*32-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    ack,
    output logic [31:0]           rdata,
    output logic                  err,
    output logic                  busy,
    sram_arb_if.master            ahb
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        ACK
    } state_t;

    typedef struct packed {
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic [2:0]    size;
        logic          wr;
        logic [IW-1:0] id;
    } xfer_t;

    state_t        state;
    xfer_t         cur;
    logic [IW-1:0] last;
    logic          err_q;
    logic [IW-1:0] win;
    logic          win_vld;
    logic [IW-1:0] cand;

`ifdef SRAM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYC - 1);
    logic [CW-1:0] cnt;
`else
    // TIMEOUT_CYC only has an effect when the watchdog is compiled in.
    if (TIMEOUT_CYC < 2) begin : g_timeout_unused
    end
`endif

    // Pick the first requester after the last winner, wrapping upward.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((int'(last) + k) % NUM_REQ);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win     = cand;
            end
        end
    end

    // Transfer sequencer: grant, address phase, data phase, ack pulse.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state      <= IDLE;
            cur        <= '0;
            last       <= IW'(NUM_REQ - 1);
            err_q      <= 1'b0;
            ack        <= '0;
            rdata      <= '0;
            err        <= 1'b0;
            busy       <= 1'b0;
            ahb.hsel   <= 1'b0;
            ahb.haddr  <= '0;
            ahb.hsize  <= '0;
            ahb.hwrite <= 1'b0;
            ahb.hwdata <= '0;
`ifdef SRAM_ARB_TIMEOUT_EN
            cnt        <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (win_vld) begin
                        cur.addr   <= req_addr[32*win +: 32];
                        cur.wdata  <= req_wdata[32*win +: 32];
                        cur.size   <= req_size[3*win +: 3];
                        cur.wr     <= req_wr[win];
                        cur.id     <= win;
                        last       <= win;
                        busy       <= 1'b1;
                        ahb.hsel   <= 1'b1;
                        ahb.haddr  <= req_addr[32*win +: 32];
                        ahb.hsize  <= req_size[3*win +: 3];
                        ahb.hwrite <= req_wr[win];
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    if (ahb.hready) begin
                        ahb.hsel   <= 1'b0;
                        ahb.haddr  <= '0;
                        ahb.hsize  <= '0;
                        ahb.hwrite <= 1'b0;
                        ahb.hwdata <= cur.wr ? cur.wdata : '0;
`ifdef SRAM_ARB_TIMEOUT_EN
                        cnt        <= '0;
`endif
                        state      <= DATA;
                    end
                end
                DATA: begin
                    err_q <= err_q | ahb.hresp;
                    if (ahb.hready) begin
                        ack        <= NUM_REQ'(1) << cur.id;
                        err        <= err_q | ahb.hresp;
                        rdata      <= (cur.wr || err_q || ahb.hresp)
                                      ? '0 : ahb.hrdata;
                        ahb.hwdata <= '0;
                        state      <= ACK;
                    end
`ifdef SRAM_ARB_TIMEOUT_EN
                    else if (cnt == LIM) begin
                        ack        <= NUM_REQ'(1) << cur.id;
                        err        <= 1'b1;
                        rdata      <= '0;
                        ahb.hwdata <= '0;
                        state      <= ACK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                ACK: begin
                    ack        <= '0;
                    rdata      <= '0;
                    err        <= 1'b0;
                    err_q      <= 1'b0;
                    busy       <= 1'b0;
                    ahb.hwdata <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_arb.sv
// Directed bench for sram_arb with a small AHB-lite SRAM stub.
// Build with SRAM_ARB_TIMEOUT_EN to exercise the watchdog path.
module tb_sram_arb;
    logic        hclk;
    logic        hreset;
    logic [1:0]  req;
    logic [63:0] req_addr;
    logic [1:0]  req_wr;
    logic [5:0]  req_size;
    logic [63:0] req_wdata;
    logic [1:0]  ack;
    logic [31:0] rdata;
    logic        err;
    logic        busy;

    int n_chk;
    int n_err;

    sram_arb_if ifc ();

    sram_arb #(
        .NUM_REQ    (2),
        .TIMEOUT_CYC(8)
    ) dut (
        .hclk     (hclk),
        .hreset   (hreset),
        .req      (req),
        .req_addr (req_addr),
        .req_wr   (req_wr),
        .req_size (req_size),
        .req_wdata(req_wdata),
        .ack      (ack),
        .rdata    (rdata),
        .err      (err),
        .busy     (busy),
        .ahb      (ifc)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // SRAM stub: 0x2000_xxxx decodes, anything else gets a 2-cycle error.
    logic [31:0] mem [0:63];
    logic        mem_init = 1'b0;
    logic        dph;
    logic [31:0] da;
    logic        dw;
    logic        err2;
    logic        stall;
    logic        ok;

    assign ok = (da[31:16] == 16'h2000);

    always @(posedge hclk) begin
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
            mem[0]   <= 32'hCAFE_0000;
            mem[4]   <= 32'hDEAD_BEEF;
            mem_init <= 1'b1;
            dph      <= 1'b0;
            err2     <= 1'b0;
            da       <= '0;
            dw       <= 1'b0;
        end else if (ifc.hsel && ifc.hready) begin
            dph <= 1'b1;
            da  <= ifc.haddr;
            dw  <= ifc.hwrite;
        end else if (dph) begin
            if (ifc.hready) begin
                dph  <= 1'b0;
                err2 <= 1'b0;
                if (dw && ok) mem[da[7:2]] <= ifc.hwdata;
            end else if (!ok) begin
                err2 <= 1'b1;
            end
        end
    end

    always_comb begin
        ifc.hready = 1'b1;
        ifc.hresp  = 1'b0;
        ifc.hrdata = '0;
        if (dph) begin
            if (stall) begin
                ifc.hready = 1'b0;
            end else if (!ok) begin
                ifc.hresp  = 1'b1;
                ifc.hready = err2;
            end else if (!dw) begin
                ifc.hrdata = mem[da[7:2]];
            end
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic set_cli(input int c, input logic [31:0] a,
                           input logic w, input logic [31:0] wd);
        req_addr[32*c +: 32]  = a;
        req_wr[c]             = w;
        req_size[3*c +: 3]    = 3'd2;
        req_wdata[32*c +: 32] = wd;
    endtask

    task automatic xfer(input int c, input logic [31:0] a,
                        input logic w, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd,
                        output logic e, output logic [1:0] av);
        set_cli(c, a, w, wd);
        req[c] = 1'b1;
        lat = 0;
        av  = '0;
        while (lat < 40 && av == 2'b00) begin
            tick();
            lat++;
            av = ack;
        end
        rd     = rdata;
        e      = err;
        req[c] = 1'b0;
    endtask

    int          lat;
    int          w;
    logic [31:0] rd;
    logic        e;
    logic [1:0]  av;
    logic [1:0]  seen;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_chk     = 0;
        n_err     = 0;
        hreset    = 1'b1;
        req       = '0;
        req_addr  = '0;
        req_wr    = '0;
        req_size  = '0;
        req_wdata = '0;
        stall     = 1'b0;
        tick();
        tick();
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_hsel", ifc.hsel, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_err", err, 0);
        hreset = 1'b0;
        tick();

        // Single read, cycle by cycle.
        set_cli(0, 32'h2000_0010, 1'b0, '0);
        req[0] = 1'b1;
        tick();
        chk("t1_hsel", ifc.hsel, 1);
        chk("t1_haddr", ifc.haddr, 32'h2000_0010);
        chk("t1_hsize", ifc.hsize, 2);
        chk("t1_busy", busy, 1);
        tick();
        chk("t1_dhsel", ifc.hsel, 0);
        chk("t1_dhaddr", ifc.haddr, 0);
        tick();
        chk("t1_ack", ack, 2'b01);
        chk("t1_rdata", rdata, 32'hDEAD_BEEF);
        chk("t1_err", err, 0);
        req[0] = 1'b0;
        tick();
        chk("t1_ackdrop", ack, 0);
        chk("t1_idle", busy, 0);

        // Client 1 writes, client 0 reads it back.
        xfer(1, 32'h2000_0020, 1'b1, 32'h1234_5678, lat, rd, e, av);
        chk("t2_wlat", lat, 3);
        chk("t2_wack", av, 2'b10);
        chk("t2_werr", e, 0);
        tick();
        xfer(0, 32'h2000_0020, 1'b0, '0, lat, rd, e, av);
        chk("t2_rack", av, 2'b01);
        chk("t2_rdata", rd, 32'h1234_5678);
        tick();

        // Both clients hold req: grants alternate from client 0.
        hreset = 1'b1;
        tick();
        hreset = 1'b0;
        set_cli(0, 32'h2000_0000, 1'b0, '0);
        set_cli(1, 32'h2000_0010, 1'b0, '0);
        req = 2'b11;
        for (int i = 0; i < 8; i++) begin
            w = 0;
            do begin
                tick();
                w++;
            end while (ack == 2'b00 && w < 20);
            chk("rr_grant", ack, (i % 2 == 0) ? 2'b01 : 2'b10);
            chk("rr_rdata", rdata,
                (i % 2 == 0) ? 32'hCAFE_0000 : 32'hDEAD_BEEF);
            chk("rr_gap", w, (i == 0) ? 3 : 4);
        end
        req = 2'b00;
        tick();

        // Decode error, then a clean read.
        xfer(0, 32'h3000_0000, 1'b0, '0, lat, rd, e, av);
        chk("de_lat", lat, 4);
        chk("de_ack", av, 2'b01);
        chk("de_err", e, 1);
        chk("de_rdata", rd, 0);
        tick();
        xfer(0, 32'h2000_0000, 1'b0, '0, lat, rd, e, av);
        chk("ok_err", e, 0);
        chk("ok_rdata", rd, 32'hCAFE_0000);
        tick();

        // Reset while in the data phase of a write.
        set_cli(0, 32'h2000_0030, 1'b1, 32'h55AA_55AA);
        req[0] = 1'b1;
        tick();
        tick();
        chk("rs_hwdata", ifc.hwdata, 32'h55AA_55AA);
        hreset = 1'b1;
        #1;
        chk("rs_hwdata0", ifc.hwdata, 0);
        chk("rs_busy0", busy, 0);
        chk("rs_hsel0", ifc.hsel, 0);
        req[0] = 1'b0;
        seen = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen |= ack;
        end
        chk("rs_noack", seen, 0);
        hreset = 1'b0;
        tick();
        xfer(1, 32'h2000_0010, 1'b0, '0, lat, rd, e, av);
        chk("rs_lat", lat, 3);
        chk("rs_ack", av, 2'b10);
        chk("rs_rdata", rd, 32'hDEAD_BEEF);
        tick();

        // Slave that never raises hready.
        stall = 1'b1;
`ifdef SRAM_ARB_TIMEOUT_EN
        xfer(0, 32'h2000_0000, 1'b0, '0, lat, rd, e, av);
        chk("to_lat", lat, 10);
        chk("to_ack", av, 2'b01);
        chk("to_err", e, 1);
        chk("to_rdata", rd, 0);
        stall = 1'b0;
        tick();
        tick();
`else
        set_cli(0, 32'h2000_0000, 1'b0, '0);
        req[0] = 1'b1;
        seen = '0;
        for (int i = 0; i < 100; i++) begin
            tick();
            seen |= ack;
        end
        chk("st_noack", seen, 0);
        chk("st_busy", busy, 1);
        stall = 1'b0;
        w = 0;
        do begin
            tick();
            w++;
        end while (ack == 2'b00 && w < 20);
        req[0] = 1'b0;
        chk("st_ack", ack, 2'b01);
        chk("st_rdata", rdata, 32'hCAFE_0000);
        chk("st_err", err, 0);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/sram_arb.md
Name: sram_arb

Overview:
- Round-robin arbiter and sequencer that shares the single AHB-lite SRAM wrapper port between NUM_REQ simple request/acknowledge clients.
- Converts each granted client request into one non-pipelined AHB-lite transfer (address phase, then data phase).
- Returns read data and error status to the winning client.
- Sits between the SRAM-side clients (CPU data path, DMA, debug) and the SRAM wrapper slave.

Parameters:
- NUM_REQ, 2, number of client ports (2..8).
- TIMEOUT_CYC, 64, data-phase wait limit in cycles; used only with SRAM_ARB_TIMEOUT_EN.

Ports:
- hclk  in  1  clock.
- hreset  in  1  reset, asynchronous, active-high.
- req  in  NUM_REQ  per-client request; held stable until ack.
- req_addr  in  NUM_REQ*32  per-client byte address; client i uses slice [32i+31:32i].
- req_wr  in  NUM_REQ  1 = write.
- req_size  in  NUM_REQ*3  per-client AHB size (0 byte, 1 half, 2 word).
- req_wdata  in  NUM_REQ*32  per-client write data.
- ack  out  NUM_REQ  one-cycle completion pulse to the granted client.
- rdata  out  32  read data; valid only while ack is high.
- err  out  1  error status; valid only while ack is high.
- busy  out  1  high while a transfer is in flight (any state other than IDLE).
- hsel  out  1  AHB select.
- haddr  out  32  AHB address.
- hsize  out  3  AHB size.
- hwrite  out  1  AHB write.
- hwdata  out  32  AHB write data (data phase).
- hrdata  in  32  AHB read data.
- hready  in  1  AHB ready from slave.
- hresp  in  1  AHB error response.

Behaviour:
- Reset values: all outputs 0; internal state IDLE; round-robin pointer last = NUM_REQ-1, so client 0 wins first.
- Reset mid-operation forces everything to reset values immediately. The in-flight transfer is abandoned and no ack is issued.
- All outputs are registered.
- FSM states: IDLE, ADDR, DATA, ACK.
- IDLE:
  - If any req bit is high, select the winner: the first requesting index after last, searching upward modulo NUM_REQ.
  - Latch the winner's id, addr, wr, size and wdata; update last = winner; go to ADDR.
  - If no req bit is high, stay in IDLE.
- ADDR:
  - hsel=1; haddr, hsize and hwrite come from the latched values.
  - If hready=1, go to DATA; otherwise hold ADDR with outputs unchanged.
- DATA:
  - hsel=0, haddr/hsize/hwrite return to 0; hwdata = latched wdata (writes only, 0 for reads).
  - An error flag is set if hresp=1 in any DATA cycle.
  - While hready=0, stay in DATA.
  - When hready=1: capture hrdata (reads only; writes return 0) and go to ACK.
- ACK:
  - ack[winner]=1 for exactly one cycle; rdata = captured data; err = error flag OR hresp at the final DATA cycle.
  - Clear the error flag, drop hwdata to 0, go to IDLE.
- Client rule: a client deasserts req on the edge where it sees ack high. A req still high in the following IDLE cycle is a new request.
- Latency with a zero-wait slave: req high in IDLE at cycle 0 → ADDR cycle 1 → DATA cycle 2 → ack in cycle 3. One transfer per 4 cycles; there is no back-to-back pipelining.
- Simultaneous requests: exactly one grant per IDLE visit. A losing client is guaranteed service within NUM_REQ-1 transfers.
- Requests arriving in ADDR, DATA or ACK are ignored until the next IDLE.
- Decode errors from the slave (the slave drives hready low one cycle with hresp high) complete with err=1 and rdata=0.

Optional Feature:
- Macro SRAM_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to DATA and increments each DATA cycle in which hready=0.
  - When it reaches TIMEOUT_CYC-1 with hready still 0, go to ACK with err=1, rdata=0.
  - hsel stays 0 and the slave response is abandoned.
- Not defined: DATA waits indefinitely for hready; no counter logic is present.

Test Plan:
- Reset then req[0]=1, read at 0x2000_0010 (word) preloaded 0xDEAD_BEEF → hsel high in cycle 1, ack[0] in cycle 3, rdata=0xDEAD_BEEF, err=0.
- Client 1 writes 0x1234_5678 to 0x2000_0020 (size 2), then client 0 reads the same address → ack[1] with err=0, then ack[0] with rdata=0x1234_5678.
- req=2'b11 held continuously (clients re-request immediately after ack) → grants alternate 0,1,0,1 for 8 transfers; no client is acked twice in a row.
- Read at 0x3000_0000 → ack with err=1, rdata=0; a following valid read at 0x2000_0000 completes with err=0.
- hreset asserted during DATA → all outputs 0 immediately, no ack; after release, req[1]=1 is served first (pointer reset, client 0 idle).
- With SRAM_ARB_TIMEOUT_EN and TIMEOUT_CYC=8, a slave stub holds hready=0 → ack pulse with err=1 exactly 8 cycles after DATA entry. Without the macro, ack never arrives.
